// File: rtl/cdr_rate_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cdr_rate_meter                                                  |
// | Purpose  : Counts CDR toggle edges over a fixed window of sys_clk cycles   |
// |            and flags counts outside the band exp_cnt +/- tol.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cdr_rate_meter #(
    parameter int WIN_CYCLES  = 1024,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_arst_n,
    input  logic             en,
    input  logic             cdr_tgl,
    input  logic [CNT_W-1:0] exp_cnt,
    input  logic [CNT_W-1:0] tol,
    output logic [CNT_W-1:0] cnt_out,
    output logic             meas_valid,
    output logic             too_fast,
    output logic             too_slow,
    output logic             cnt_sat,
    output logic             busy
);

    localparam int WIN_W = $clog2(WIN_CYCLES);
    localparam int SET_W = $clog2(SYNC_STAGES + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t                 state_q,    state_d;
    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    logic                   hist_q,     hist_d;
    logic [SET_W-1:0]       settle_q,   settle_d;
    logic [WIN_W-1:0]       win_q,      win_d;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic                   sat_q,      sat_d;
    logic [CNT_W-1:0]       cnt_out_q,  cnt_out_d;
    logic                   valid_q,    valid_d;
    logic                   fast_q,     fast_d;
    logic                   slow_q,     slow_d;
    logic                   csat_q,     csat_d;
    logic                   busy_q,     busy_d;

    logic                   tgl_edge;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   sat_inc;
    logic [CNT_W:0]         cnt_ext;
    logic [CNT_W:0]         exp_ext;
    logic [CNT_W:0]         tol_ext;

    // Synchronizer and history flop run unconditionally so no edge is lost
    // across window boundaries.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], cdr_tgl};
        hist_d   = sync_q[SYNC_STAGES-1];
        tgl_edge = sync_q[SYNC_STAGES-1] ^ hist_q;
    end

    always_comb begin
        cnt_inc = edge_cnt_q;
        sat_inc = 1'b0;
        if (tgl_edge) begin
            if (edge_cnt_q == CNT_MAX) begin
                sat_inc = 1'b1;
            end else begin
                cnt_inc = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    // One extra bit keeps exp_cnt + tol and cnt + tol from wrapping.
    always_comb begin
        cnt_ext = {1'b0, cnt_inc};
        exp_ext = {1'b0, exp_cnt};
        tol_ext = {1'b0, tol};
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        win_d      = win_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        cnt_out_d  = cnt_out_q;
        fast_d     = fast_q;
        slow_d     = slow_q;
        csat_d     = csat_q;
        valid_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                settle_d   = '0;
                win_d      = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (en) begin
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                win_d      = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (!en) begin
                    state_d  = ST_IDLE;
                    settle_d = '0;
                end else if (settle_q == SET_LAST) begin
                    state_d  = ST_MEASURE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end

            ST_MEASURE: begin
                if (win_q == WIN_LAST) begin
                    cnt_out_d  = cnt_inc;
                    csat_d     = sat_q | sat_inc;
                    fast_d     = cnt_ext > (exp_ext + tol_ext);
                    slow_d     = (cnt_ext + tol_ext) < exp_ext;
                    valid_d    = 1'b1;
                    win_d      = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    if (!en) begin
                        state_d = ST_IDLE;
                    end
                end else if (!en) begin
                    state_d    = ST_IDLE;
                    win_d      = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else begin
                    win_d      = win_q + WIN_W'(1);
                    edge_cnt_d = cnt_inc;
                    sat_d      = sat_q | sat_inc;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                settle_d   = '0;
                win_d      = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_arst_n) begin
        if (!sys_arst_n) begin
            state_q    <= ST_IDLE;
            sync_q     <= '0;
            hist_q     <= 1'b0;
            settle_q   <= '0;
            win_q      <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            cnt_out_q  <= '0;
            valid_q    <= 1'b0;
            fast_q     <= 1'b0;
            slow_q     <= 1'b0;
            csat_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            settle_q   <= settle_d;
            win_q      <= win_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            cnt_out_q  <= cnt_out_d;
            valid_q    <= valid_d;
            fast_q     <= fast_d;
            slow_q     <= slow_d;
            csat_q     <= csat_d;
            busy_q     <= busy_d;
        end
    end

    assign cnt_out    = cnt_out_q;
    assign meas_valid = valid_q;
    assign too_fast   = fast_q;
    assign too_slow   = slow_q;
    assign cnt_sat    = csat_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire
